// File: rtl/ula_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops, shift-add multiply and optional restoring divide.
// Define ULA_SEQ_DIV_EN to build the DIVU/REMU datapath; otherwise ops 9/10 are reported illegal.
module ula_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             div_zero,
  output logic             illegal
);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_SLT   = 4'd4;
  localparam logic [3:0] OP_SLTU  = 4'd5;
  localparam logic [3:0] OP_NOR   = 4'd6;
  localparam logic [3:0] OP_MUL   = 4'd7;
  localparam logic [3:0] OP_MULHU = 4'd8;
  localparam logic [3:0] OP_DIVU  = 4'd9;
  localparam logic [3:0] OP_REMU  = 4'd10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             op_q, op_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
  logic                   neg_q, neg_d, divz_q, divz_d, ill_q, ill_d;
`ifdef ULA_SEQ_DIV_EN
  logic [WIDTH-1:0]       b_q, b_d;
`endif

  // Single-cycle datapath, evaluated on the live inputs so the result is captured on acceptance
  logic [WIDTH:0]         add_w, sub_w;
  logic [WIDTH-1:0]       q_res;
  logic                   q_carry, q_ovf, q_divz, q_ill, q_multi, q_div;

  always_comb begin
    add_w   = {1'b0, a} + {1'b0, b};
    sub_w   = {1'b0, a} - {1'b0, b};
    q_res   = '0;
    q_carry = 1'b0;
    q_ovf   = 1'b0;
    q_divz  = 1'b0;
    q_ill   = 1'b0;
    q_multi = 1'b0;
    q_div   = 1'b0;
    case (op)
      OP_AND:  q_res = a & b;
      OP_OR:   q_res = a | b;
      OP_ADD: begin
        q_res   = add_w[WIDTH-1:0];
        q_carry = add_w[WIDTH];
        q_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        q_res   = sub_w[WIDTH-1:0];
        q_carry = sub_w[WIDTH];
        q_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  q_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: q_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_NOR:  q_res = ~(a | b);
      OP_MUL, OP_MULHU: q_multi = 1'b1;
`ifdef ULA_SEQ_DIV_EN
      OP_DIVU, OP_REMU: begin
        if (b == '0) begin
          q_divz = 1'b1;
          q_res  = (op == OP_DIVU) ? '1 : a;
        end else begin
          q_multi = 1'b1;
          q_div   = 1'b1;
        end
      end
`else
      OP_DIVU, OP_REMU: q_ill = 1'b1;
`endif
      default: q_ill = 1'b1;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide; prod_q holds {hi, lo}
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_next, step_next;
`ifdef ULA_SEQ_DIV_EN
  logic [WIDTH:0]         rem_sh, div_diff;
  logic [2*WIDTH-1:0]     div_next;
`endif

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    mul_next  = prod_q[0] ? {mul_sum, prod_q[WIDTH-1:1]} : {1'b0, prod_q[2*WIDTH-1:1]};
    step_next = mul_next;
`ifdef ULA_SEQ_DIV_EN
    rem_sh    = prod_q[2*WIDTH-1:WIDTH-1];
    div_diff  = rem_sh - {1'b0, b_q};
    div_next  = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    if (op_q == OP_DIVU || op_q == OP_REMU) step_next = div_next;
`endif
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;
    divz_d   = divz_q;
    ill_d    = ill_q;
`ifdef ULA_SEQ_DIV_EN
    b_d      = b_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = op;
          a_d   = a;
          cnt_d = '0;
`ifdef ULA_SEQ_DIV_EN
          b_d   = b;
`endif
          if (q_multi) begin
            state_d = BUSY;
            prod_d  = q_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
          end else begin
            state_d  = DONE;
            result_d = q_res;
            carry_d  = q_carry;
            ovf_d    = q_ovf;
            divz_d   = q_divz;
            ill_d    = q_ill;
          end
        end
      end
      BUSY: begin
        prod_d = step_next;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = (op_q == OP_MULHU || op_q == OP_REMU) ? step_next[2*WIDTH-1:WIDTH]
                                                          : step_next[WIDTH-1:0];
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          divz_d   = 1'b0;
          ill_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // zero/negative always follow the result being loaded, including the illegal path
    if (state_d == DONE && state_q != DONE) begin
      zero_d = (result_d == '0);
      neg_d  = result_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      divz_q   <= 1'b0;
      ill_q    <= 1'b0;
`ifdef ULA_SEQ_DIV_EN
      b_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
      divz_q   <= divz_d;
      ill_q    <= ill_d;
`ifdef ULA_SEQ_DIV_EN
      b_q      <= b_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign negative  = neg_q;
  assign div_zero  = divz_q;
  assign illegal   = ill_q;

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Parametrised multi-cycle ALU. Successor to the single-cycle combinational ALU.
- Keeps the logic and arithmetic op set: AND, OR, ADD, SUB, SLT, SLTU, NOR.
- Adds iterative unsigned multiply and optional iterative unsigned divide/remainder.
- Adds valid/ready handshakes on both sides and a full status-flag set. Sits between decode/issue and writeback.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- op  in  4  opcode: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 SLTU, 6 NOR, 7 MUL (low half), 8 MULHU (high half), 9 DIVU, 10 REMU; 11-15 illegal.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  result.
- zero  out  1  result == 0, all WIDTH bits.
- carry  out  1  ADD carry-out; SUB borrow (a<b unsigned); else 0.
- overflow  out  1  signed overflow for ADD/SUB; else 0.
- negative  out  1  result[WIDTH-1].
- div_zero  out  1  DIVU/REMU with b==0.
- illegal  out  1  opcode 11-15, or DIVU/REMU when compiled out.

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (rst=1 at clk edge, any state): state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0, counter=0. An operation in progress is discarded; no output is produced for it.
- in_ready=1 only in IDLE. A request is accepted on in_valid&&in_ready; a, b and op are registered on that edge.
- Single-cycle ops (0-6) and illegal ops: IDLE→DONE. out_valid rises the cycle after acceptance (latency 1).
- SLT is a signed compare; SLTU is unsigned. Both return 1 or 0, zero-extended to WIDTH.
- Illegal op: result=0, illegal=1, zero=1.
- MUL/MULHU: IDLE→BUSY. Shift-add, one bit per cycle, 2*WIDTH-bit product.
  - BUSY lasts exactly WIDTH cycles, then DONE. Latency WIDTH+1.
  - MUL returns product[WIDTH-1:0]; MULHU returns product[2*WIDTH-1:WIDTH].
- DIVU/REMU: restoring division, same timing as MUL (latency WIDTH+1).
  - b==0 bypasses BUSY (latency 1): DIVU result = all ones, REMU result = a, div_zero=1.
- DONE: out_valid=1. result and flags are held stable until out_valid&&out_ready. On that handshake: →IDLE, out_valid=0 next cycle.
- No back-to-back issue. The next request is accepted no earlier than the cycle after the output handshake. Minimum issue interval is 2 cycles.
- in_valid during BUSY/DONE is ignored; the requester must hold it until in_ready.
- Operand changes after acceptance have no effect.
- Flags not listed for an op are 0. Flags are registered together with result.

Optional Feature:
- Macro: ULA_SEQ_DIV_EN.
- Defined: DIVU/REMU implemented as above.
- Undefined: no divider hardware. Ops 9/10 take the illegal path: latency 1, result=0, illegal=1, div_zero=0.

Test Plan:
- WIDTH=8, op=ADD, a=0xF0, b=0x20 → after 1 cycle: result=0x10, carry=1, overflow=0, zero=0.
- WIDTH=8, op=SUB, a=0x80, b=0x01 → result=0x7F, overflow=1, carry=0, negative=0. Then SLT a=0x80, b=0x01 → result=1; SLTU, same operands → result=0.
- WIDTH=8, op=MUL, a=0x0F, b=0x11 → out_valid exactly 9 cycles after acceptance, result=0xFF. MULHU, same operands → result=0x00.
- WIDTH=8, with ULA_SEQ_DIV_EN: DIVU 0xC8/0x07 → result=0x1C after 9 cycles; REMU → 0x04; DIVU b=0 → result=0xFF, div_zero=1, latency 1. Without the macro: DIVU → illegal=1, result=0.
- Hold out_ready=0 for 5 cycles in DONE while driving in_valid with new ops → result and flags stable, in_ready=0. Release out_ready → IDLE, next op accepted.
- Assert rst mid-MUL (BUSY cycle 4) → next cycle IDLE, out_valid=0, result=0; no stale result appears later.
